// File: rtl/ae_act_pkg.sv
// Shared activation-datapath definitions: mode encodings and default lane format
// common to the MAC stage and the activation unit.
package ae_act_pkg;

    localparam int AE_NBITS = 16;
    localparam int AE_FRAC  = 8;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLAMP = 2'd3
    } act_mode_e;

endpackage

// File: rtl/relu_act_lane.sv
// One lane of the activation unit: applies the selected activation to x.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module relu_act_lane
    import ae_act_pkg::*;
#(
    parameter int               NBITS      = AE_NBITS,
    parameter int               LEAK_SHIFT = 3,
    parameter logic [NBITS-1:0] CLAMP_MAX  = NBITS'(6 << AE_FRAC)
) (
    input  logic [NBITS-1:0] x,
    input  logic [1:0]       mode,
    input  logic             neg,
    input  logic             over,
    output logic [NBITS-1:0] y,
    output logic             clipped
);

    // neg/over are precomputed one stage earlier to keep this path short
    always_comb begin
        y = x;
        case (act_mode_e'(mode))
            ACT_RELU: begin
                if (neg) y = '0;
            end
            ACT_LEAKY: begin
                if (neg) y = $signed(x) >>> LEAK_SHIFT;
            end
            ACT_CLAMP: begin
                if (neg)       y = '0;
                else if (over) y = CLAMP_MAX;
            end
            default: y = x;
        endcase
        clipped = (y != x);
    end

endmodule

// File: rtl/relu_act_pipe.sv
// Multi-lane pipelined activation unit with per-beat mode and saturating clip counter.
// Latency: 2 clk from input transfer to out_valid, 1 beat/clk throughput.
// Backpressure: each stage advances when its successor is empty or draining; out_ready->in_ready is combinational.
module relu_act_pipe
    import ae_act_pkg::*;
#(
    parameter int NBITS      = AE_NBITS,
    parameter int FRAC       = AE_FRAC,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 6 << FRAC,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [LANES*NBITS-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*NBITS-1:0] out_data,
    input  logic                   stat_clr,
    output logic [CNT_W-1:0]       clip_cnt
);

    localparam int               DW      = LANES * NBITS;
    localparam int               PW      = $clog2(LANES + 1);
    localparam int               SW      = CNT_W + PW;
    localparam logic [NBITS-1:0] CLAMP_V = CLAMP_MAX[NBITS-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_vld_q, s1_vld_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic [DW-1:0]    s1_dat_q, s1_dat_d;
    logic [LANES-1:0] s1_neg_q, s1_neg_d;
    logic [LANES-1:0] s1_over_q, s1_over_d;

    logic             s2_vld_q, s2_vld_d;
    logic [DW-1:0]    s2_dat_q, s2_dat_d;
    logic [CNT_W-1:0] clip_cnt_q, clip_cnt_d;

    logic             s2_acc;
    logic             s2_ld;
    logic             in_fire;
    logic [DW-1:0]    act_dat;
    logic [LANES-1:0] act_clip;
    logic [PW-1:0]    clip_pop;
    logic [SW-1:0]    clip_sum;

    assign s2_acc   = !s2_vld_q || out_ready;
    assign s2_ld    = s1_vld_q && s2_acc;
    assign in_ready = !rst && (!s1_vld_q || s2_acc);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_mode_d = s1_mode_q;
        s1_dat_d  = s1_dat_q;
        s1_neg_d  = s1_neg_q;
        s1_over_d = s1_over_q;
        if (in_fire) begin
            s1_vld_d  = 1'b1;
            s1_mode_d = in_mode;
            s1_dat_d  = in_data;
            for (int i = 0; i < LANES; i++) begin
                s1_neg_d[i]  = in_data[i*NBITS + NBITS - 1];
                s1_over_d[i] = !in_data[i*NBITS + NBITS - 1] &&
                               ($signed(in_data[i*NBITS +: NBITS]) > $signed(CLAMP_V));
            end
        end else if (s2_ld) begin
            s1_vld_d = 1'b0;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        relu_act_lane #(
            .NBITS      (NBITS),
            .LEAK_SHIFT (LEAK_SHIFT),
            .CLAMP_MAX  (CLAMP_V)
        ) u_lane (
            .x       (s1_dat_q[g*NBITS +: NBITS]),
            .mode    (s1_mode_q),
            .neg     (s1_neg_q[g]),
            .over    (s1_over_q[g]),
            .y       (act_dat[g*NBITS +: NBITS]),
            .clipped (act_clip[g])
        );
    end

    always_comb begin
        s2_vld_d = s2_vld_q;
        s2_dat_d = s2_dat_q;
        if (s2_acc) s2_vld_d = s1_vld_q;
        if (s2_ld)  s2_dat_d = act_dat;
    end

    // clear wins over a same-cycle increment, so that beat's clips are dropped
    always_comb begin
        clip_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            clip_pop = clip_pop + PW'(act_clip[i]);
        end
        clip_sum   = SW'(clip_cnt_q) + SW'(clip_pop);
        clip_cnt_d = clip_cnt_q;
        if (stat_clr) begin
            clip_cnt_d = '0;
        end else if (s2_ld) begin
            clip_cnt_d = (clip_sum > SW'(CNT_MAX)) ? CNT_MAX : clip_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_mode_q  <= '0;
            s1_dat_q   <= '0;
            s1_neg_q   <= '0;
            s1_over_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_dat_q   <= '0;
            clip_cnt_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_mode_q  <= s1_mode_d;
            s1_dat_q   <= s1_dat_d;
            s1_neg_q   <= s1_neg_d;
            s1_over_q  <= s1_over_d;
            s2_vld_q   <= s2_vld_d;
            s2_dat_q   <= s2_dat_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_data  = s2_dat_q;
    assign clip_cnt  = clip_cnt_q;

endmodule

// File: tb/tb_relu_act_pipe.sv
// Directed bench for relu_act_pipe: scoreboard of expected beats, per-cycle handshake checks.
module tb_relu_act_pipe;
    import ae_act_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        stat_clr;
    logic [3:0]  clip_cnt;

    relu_act_pipe #(
        .NBITS(16), .FRAC(8), .LANES(4), .LEAK_SHIFT(3), .CLAMP_MAX('h600), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stat_clr(stat_clr), .clip_cnt(clip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_clip = 0;
    logic [63:0] cur_exp;
    int          cur_clips;
    logic        last_in_fire;
    logic        stall_q = 1'b0;
    logic [63:0] held_dat;
    logic        rnd_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    // Independent integer reference: floor-division instead of shifting
    function automatic logic [15:0] model_lane(input logic [15:0] x, input logic [1:0] m);
        int v;
        v = int'($signed(x));
        case (m)
            2'd1: if (v < 0) v = 0;
            2'd2: if (v < 0) v = -((-v + 7) / 8);
            2'd3: begin
                if (v < 0) v = 0;
                else if (v > 1536) v = 1536;
            end
            default: ;
        endcase
        return v[15:0];
    endfunction

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = !rst && !(sb.size() == 2 && !out_ready);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (stall_q) check("stall_hold", {63'(out_data[62:0]) , 1'b0} | 64'(out_valid), {63'(held_dat[62:0]), 1'b0} | 64'd1);
        if (stall_q) check("stall_msb", 64'(out_data[63]), 64'(held_dat[63]));
        if (out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                check("out_data", out_data, sb.pop_front());
            end
        end
        stall_q  = (out_valid === 1'b1) && !out_ready && !rst;
        held_dat = out_data;
        last_in_fire = in_valid && (in_ready === 1'b1);
        if (last_in_fire) begin
            sb.push_back(cur_exp);
            exp_clip = (exp_clip + cur_clips > 15) ? 15 : exp_clip + cur_clips;
        end
        @(posedge clk);
        #1;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [1:0] m, input logic [63:0] d,
                             input logic [63:0] e, input int c);
        logic got;
        in_valid = 1'b1; in_mode = m; in_data = d; cur_exp = e; cur_clips = c;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            tick();
            got = last_in_fire;
        end
        if (!got) check("in_timeout", 64'(got), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [1:0] m, input logic [63:0] d);
        logic [63:0] e;
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            e[i*16 +: 16] = model_lane(d[i*16 +: 16], m);
            if (e[i*16 +: 16] != d[i*16 +: 16]) c++;
        end
        send_beat(m, d, e, c);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_data = '0;
        out_ready = 1'b1; stat_clr = 1'b0; cur_exp = '0; cur_clips = 0;
        last_in_fire = 1'b0; held_dat = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_clip_cnt", 64'(clip_cnt), 64'd0);

        // RELU beat and two-cycle latency
        send_beat(ACT_RELU, pack4(16'h0180, 16'hFE00, 16'h0000, 16'h7FFF),
                  pack4(16'h0180, 16'h0000, 16'h0000, 16'h7FFF), 1);
        check("t1_lat_s1", 64'(out_valid), 64'd0);
        tick();
        check("t1_lat_s2", 64'(out_valid), 64'd1);
        drain();
        check("t1_clip", 64'(clip_cnt), 64'd1);

        // LEAKY including most-negative and -1
        send_beat(ACT_LEAKY, pack4(16'hFE00, 16'h8000, 16'h0010, 16'hFFFF),
                  pack4(16'hFFC0, 16'hF000, 16'h0010, 16'hFFFF), 2);
        drain();
        check("t2_clip", 64'(clip_cnt), 64'd3);

        // CLAMP then IDENT on the same data, back to back
        send_beat(ACT_CLAMP, pack4(16'h0700, 16'h0600, 16'hFF00, 16'h0100),
                  pack4(16'h0600, 16'h0600, 16'h0000, 16'h0100), 2);
        send_beat(ACT_IDENT, pack4(16'h0700, 16'h0600, 16'hFF00, 16'h0100),
                  pack4(16'h0700, 16'h0600, 16'hFF00, 16'h0100), 0);
        drain();
        check("t3_clip", 64'(clip_cnt), 64'd5);

        // Back-to-back mixed modes with random backpressure
        rnd_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            send_model(2'($urandom_range(0, 3)), {$urandom, $urandom});
        end
        drain();
        rnd_en = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_clip", 64'(clip_cnt), 64'(exp_clip));

        // Saturation at CNT_W=4
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        exp_clip = 0;
        check("t5_clr", 64'(clip_cnt), 64'd0);
        for (int b = 0; b < 3; b++)
            send_model(ACT_RELU, pack4(16'h8000, 16'hFFFF, 16'hF000, 16'h8001));
        send_model(ACT_RELU, pack4(16'h8000, 16'h0001, 16'hF000, 16'h0100));
        drain();
        check("t5_clip14", 64'(clip_cnt), 64'd14);
        send_model(ACT_RELU, pack4(16'h8000, 16'hFFFF, 16'hF000, 16'h8001));
        drain();
        check("t5_clip15", 64'(clip_cnt), 64'd15);
        send_model(ACT_RELU, pack4(16'h8000, 16'hFFFF, 16'hF000, 16'h8001));
        drain();
        check("t5_sat_hold", 64'(clip_cnt), 64'd15);
        send_model(ACT_RELU, pack4(16'h8000, 16'hFFFF, 16'hF000, 16'h8001));
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        drain();
        exp_clip = 0;
        check("t5_clr_wins", 64'(clip_cnt), 64'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        send_model(ACT_RELU, pack4(16'hFFFF, 16'h0001, 16'h0002, 16'h0003));
        send_model(ACT_IDENT, pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444));
        check("t6_full_rdy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_clip = 0;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_clip_cnt", 64'(clip_cnt), 64'd0);
        check("t6_out_data", out_data, 64'd0);
        out_ready = 1'b1;
        send_model(ACT_LEAKY, pack4(16'hFF00, 16'h0042, 16'h8008, 16'h7000));
        check("t6_lat_s1", 64'(out_valid), 64'd0);
        tick();
        check("t6_lat_s2", 64'(out_valid), 64'd1);
        drain();
        check("t6_clip", 64'(clip_cnt), 64'(exp_clip));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
